// File: rtl/rpn_sequencer_if.sv
// rtl/rpn_sequencer_if.sv - command/result handshake bundle for rpn_sequencer
interface rpn_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_carry;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, res_valid, res_data, res_carry, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, res_valid, res_data, res_carry, err, err_code
  );
endinterface

// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - RPN command sequencer, sole push/pop master of the hardware stack
module rpn_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 8,
  parameter int POP_LAT    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rpn_sequencer_if.slave        cmd_bus,
  output logic                  o_stk_push,
  output logic                  o_stk_pop,
  output logic [DATA_WIDTH-1:0] o_stk_wr_data,
  input  logic [DATA_WIDTH-1:0] i_stk_rd_data,
  input  logic [ADDR_BITS-1:0]  i_stk_sp,
  input  logic                  i_stk_overflow,
  input  logic                  i_stk_underflow
);
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DUP  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_DROP = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int                   WW        = $clog2(POP_LAT + 1);
  localparam logic [WW-1:0]        WAIT_LOAD = WW'(POP_LAT - 1);
  localparam logic [ADDR_BITS-1:0] SP_MAX    = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_POP_A, S_WAIT_A, S_POP_B, S_WAIT_B, S_EXEC, S_PUSH_1, S_PUSH_2, S_DONE
  } state_t;

  state_t                r_state;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [WW-1:0]         r_wait;
  logic [DATA_WIDTH-1:0] r_rpt;
  logic                  r_carry;
  logic                  r_cmd_ready;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_carry;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic                  r_stk_push;
  logic                  r_stk_pop;
  logic [DATA_WIDTH-1:0] r_stk_wr_data;

  logic                  w_few;
  logic                  w_full;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0] w_alu;
  logic                  w_alu_c;

  // Admission checks look at the incoming op, not r_op, since they decide acceptance.
  always_comb begin
    w_few  = 1'b0;
    w_full = 1'b0;
    case (cmd_bus.cmd_op)
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: w_few = (i_stk_sp < ADDR_BITS'(2));
      OP_DROP:                         w_few = (i_stk_sp == '0);
      OP_DUP: begin
        w_few  = (i_stk_sp == '0);
        w_full = (i_stk_sp == SP_MAX);
      end
      OP_PUSH:                         w_full = (i_stk_sp == SP_MAX);
      default: ;
    endcase
  end

  assign w_sum  = {1'b0, r_b} + {1'b0, r_a};
  assign w_diff = {1'b0, r_b} - {1'b0, r_a};
  assign w_prod = r_b * r_a;

  always_comb begin
    w_alu   = w_prod;
    w_alu_c = 1'b0;
    if (r_op == OP_ADD) begin
      w_alu   = w_sum[DATA_WIDTH-1:0];
      w_alu_c = w_sum[DATA_WIDTH];
    end else if (r_op == OP_SUB) begin
      w_alu   = w_diff[DATA_WIDTH-1:0];
      w_alu_c = w_diff[DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_NOP;
      r_a           <= '0;
      r_b           <= '0;
      r_wait        <= '0;
      r_rpt         <= '0;
      r_carry       <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_carry   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
      r_stk_push    <= 1'b0;
      r_stk_pop     <= 1'b0;
      r_stk_wr_data <= '0;
    end else begin
      r_stk_push    <= 1'b0;
      r_stk_pop     <= 1'b0;
      r_stk_wr_data <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_carry   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_bus.cmd_op;
            r_rpt       <= '0;
            r_carry     <= 1'b0;
            if (i_stk_overflow || i_stk_underflow) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_err       <= 1'b1;
              r_err_code  <= 2'b11;
            end else if (w_few) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_err       <= 1'b1;
              r_err_code  <= 2'b01;
            end else if (w_full) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_err       <= 1'b1;
              r_err_code  <= 2'b10;
            end else if (cmd_bus.cmd_op == OP_PUSH) begin
              r_state       <= S_PUSH_1;
              r_stk_push    <= 1'b1;
              r_stk_wr_data <= cmd_bus.cmd_data;
              r_rpt         <= cmd_bus.cmd_data;
            end else if (cmd_bus.cmd_op == OP_NOP) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
            end else begin
              r_state   <= S_POP_A;
              r_stk_pop <= 1'b1;
            end
          end
        end
        S_POP_A: begin
          r_state <= S_WAIT_A;
          r_wait  <= WAIT_LOAD;
        end
        S_WAIT_A: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            r_a <= i_stk_rd_data;
            if (r_op == OP_DROP) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
            end else if (r_op == OP_DUP) begin
              r_state       <= S_PUSH_1;
              r_stk_push    <= 1'b1;
              r_stk_wr_data <= i_stk_rd_data;
              r_rpt         <= i_stk_rd_data;
            end else begin
              r_state   <= S_POP_B;
              r_stk_pop <= 1'b1;
            end
          end
        end
        S_POP_B: begin
          r_state <= S_WAIT_B;
          r_wait  <= WAIT_LOAD;
        end
        S_WAIT_B: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            r_b <= i_stk_rd_data;
            if (r_op == OP_SWAP) begin
              r_state       <= S_PUSH_1;
              r_stk_push    <= 1'b1;
              r_stk_wr_data <= r_a;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_rpt         <= w_alu;
          r_carry       <= w_alu_c;
          r_state       <= S_PUSH_1;
          r_stk_push    <= 1'b1;
          r_stk_wr_data <= w_alu;
        end
        S_PUSH_1: begin
          if (r_op == OP_DUP || r_op == OP_SWAP) begin
            r_state       <= S_PUSH_2;
            r_stk_push    <= 1'b1;
            r_stk_wr_data <= (r_op == OP_DUP) ? r_a : r_b;
          end else begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_data  <= r_rpt;
            r_res_carry <= r_carry;
          end
        end
        S_PUSH_2: begin
          // SWAP leaves r_rpt at zero, so only DUP reports a value here.
          r_state     <= S_DONE;
          r_res_valid <= 1'b1;
          r_res_data  <= r_rpt;
          r_res_carry <= r_carry;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_bus.cmd_ready = r_cmd_ready;
  assign cmd_bus.res_valid = r_res_valid;
  assign cmd_bus.res_data  = r_res_data;
  assign cmd_bus.res_carry = r_res_carry;
  assign cmd_bus.err       = r_err;
  assign cmd_bus.err_code  = r_err_code;
  assign o_stk_push        = r_stk_push;
  assign o_stk_pop         = r_stk_pop;
  assign o_stk_wr_data     = r_stk_wr_data;
endmodule
